// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch path: fetch FSM states,
// read-latency limits and the default address width.
package proc_pkg;

  localparam int ADDR_W_DEFAULT = 8;

  // Legal IRAM read latency range, in cycles from iram_rd to valid data.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wait counter width: it only ever holds RD_LAT-2, at most 2.
  localparam int LAT_CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_LATCH  = 3'd3,
    S_DONE   = 3'd4,
    S_LOADER = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the control unit / program loader (master side)
// and the fetch controller (slave side).
interface fetch_ctrl_if
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              fetch_req;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              ldr_req;
  logic              ldr_gnt;
  logic [ADDR_W-1:0] iram_addr;
  logic              iram_rd;
  logic              mbru_read_enable;
  logic              ins_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;

  modport master (
    output fetch_req, jump, jump_addr, ldr_req,
    input  ldr_gnt, iram_addr, iram_rd, mbru_read_enable, ins_valid, pc, busy
  );

  modport slave (
    input  fetch_req, jump, jump_addr, ldr_req,
    output ldr_gnt, iram_addr, iram_rd, mbru_read_enable, ins_valid, pc, busy
  );

endinterface

// File: rtl/lat_counter.sv
// Down-counter that times the IRAM read latency: loaded when the read is
// issued, decremented while waiting, zero flag ends the wait.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Load takes priority over decrement; the count never underflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences one IRAM read per fetch request,
// tells the MBRU when to latch the data, advances/redirects the PC and
// arbitrates IRAM ownership with the program loader.
module fetch_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         rst_n,
  fetch_ctrl_if.slave bus
);

  // WAIT covers RD_LAT-1 cycles; the counter runs RD_LAT-2 down to 0.
  localparam logic [LAT_CNT_W-1:0] WAIT_LOAD =
    LAT_CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  fetch_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic              pend_valid_reg;
  logic [ADDR_W-1:0] iram_addr_reg;
  logic              iram_rd_reg, mbru_en_reg, ins_valid_reg, ldr_gnt_reg, busy_reg;
  logic [ADDR_W-1:0] idle_target;
  logic [ADDR_W-1:0] latch_target;
  logic              cnt_zero;

  lat_counter #(.W(LAT_CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_reg == S_READ),
    .load_val (WAIT_LOAD),
    .dec      (state_reg == S_WAIT),
    .zero     (cnt_zero)
  );

  // A jump seen this cycle beats an older pending jump, which beats the plain PC.
  assign idle_target  = bus.jump ? bus.jump_addr :
                        (pend_valid_reg ? pend_addr_reg : pc_reg);
  assign latch_target = bus.jump ? bus.jump_addr :
                        (pend_valid_reg ? pend_addr_reg : pc_reg + ADDR_W'(1));

  // Next-state selection; the loader is only ever admitted from IDLE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.ldr_req)        state_next = S_LOADER;
        else if (bus.fetch_req) state_next = S_READ;
      end
      S_READ:   state_next = (RD_LAT > 1) ? S_WAIT : S_LATCH;
      S_WAIT:   state_next = cnt_zero ? S_LATCH : S_WAIT;
      S_LATCH:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      S_LOADER: state_next = bus.ldr_req ? S_LOADER : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State, PC and pending-jump bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      pc_reg         <= '0;
      pend_addr_reg  <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        S_IDLE: begin
          pc_reg         <= idle_target;
          pend_valid_reg <= 1'b0;
        end
        S_LATCH: begin
          pc_reg         <= latch_target;
          pend_valid_reg <= 1'b0;
        end
        S_LOADER: begin
          if (!bus.ldr_req) pc_reg <= '0;
        end
        default: begin
          if (bus.jump) begin
            pend_valid_reg <= 1'b1;
            pend_addr_reg  <= bus.jump_addr;
          end
        end
      endcase
    end
  end

  // Outputs are registered from the next state so each strobe is glitch-free
  // and lines up exactly with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iram_addr_reg <= '0;
      iram_rd_reg   <= 1'b0;
      mbru_en_reg   <= 1'b0;
      ins_valid_reg <= 1'b0;
      ldr_gnt_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if ((state_reg == S_IDLE) && (state_next == S_READ)) iram_addr_reg <= idle_target;
      iram_rd_reg   <= (state_next == S_READ);
      mbru_en_reg   <= (state_next == S_LATCH);
      ins_valid_reg <= (state_next == S_DONE);
      ldr_gnt_reg   <= (state_next == S_LOADER);
      busy_reg      <= (state_next != S_IDLE);
    end
  end

  assign bus.pc               = pc_reg;
  assign bus.iram_addr        = iram_addr_reg;
  assign bus.iram_rd          = iram_rd_reg;
  assign bus.mbru_read_enable = mbru_en_reg;
  assign bus.ins_valid        = ins_valid_reg;
  assign bus.ldr_gnt          = ldr_gnt_reg;
  assign bus.busy             = busy_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share the
// same stimulus; a timeline-based reference model predicts every output
// every cycle, plus directed scenarios with fixed expected values.
module tb_fetch_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fr = 1'b0;
  logic          jmp = 1'b0;
  logic          lr = 1'b0;
  logic [AW-1:0] ja = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  fetch_ctrl_if #(.ADDR_W(AW)) bus1 ();
  fetch_ctrl_if #(.ADDR_W(AW)) bus3 ();

  assign bus1.fetch_req = fr;
  assign bus1.jump      = jmp;
  assign bus1.jump_addr = ja;
  assign bus1.ldr_req   = lr;
  assign bus3.fetch_req = fr;
  assign bus3.jump      = jmp;
  assign bus3.jump_addr = ja;
  assign bus3.ldr_req   = lr;

  fetch_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fetch_ctrl #(.ADDR_W(AW), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  // Reference model: each fetch is a timeline of cycles k = 1 .. lat+2
  // (k=1 read strobe, k=lat+1 MBRU enable, k=lat+2 instruction valid).
  int            lat [2] = '{1, 3};
  logic [AW-1:0] m_pc [2];
  logic [AW-1:0] m_pend_a [2];
  logic [AW-1:0] m_iaddr [2];
  bit            m_pend_v [2];
  bit            m_fetch [2];
  bit            m_ldr [2];
  int            m_k [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_pend_a[i] = '0; m_iaddr[i] = '0;
      m_pend_v[i] = 0; m_fetch[i] = 0; m_ldr[i] = 0; m_k[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [AW-1:0] eff;
    for (int i = 0; i < 2; i++) begin
      if (!m_fetch[i] && !m_ldr[i]) begin
        eff = jmp ? ja : (m_pend_v[i] ? m_pend_a[i] : m_pc[i]);
        m_pc[i] = eff;
        m_pend_v[i] = 0;
        if (lr) m_ldr[i] = 1;
        else if (fr) begin
          m_fetch[i] = 1; m_k[i] = 1; m_iaddr[i] = eff;
        end
      end else if (m_ldr[i]) begin
        if (!lr) begin
          m_ldr[i] = 0; m_pc[i] = '0;
        end
      end else begin
        if (m_k[i] == lat[i] + 1) begin
          m_pc[i] = jmp ? ja : (m_pend_v[i] ? m_pend_a[i] : m_pc[i] + 8'd1);
          m_pend_v[i] = 0;
        end else if (jmp) begin
          m_pend_v[i] = 1; m_pend_a[i] = ja;
        end
        m_k[i]++;
        if (m_k[i] > lat[i] + 2) m_fetch[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] g_pc, g_ia;
    logic g_rd, g_mb, g_iv, g_gnt, g_busy;
    string p;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        g_pc = bus1.pc; g_ia = bus1.iram_addr; g_rd = bus1.iram_rd;
        g_mb = bus1.mbru_read_enable; g_iv = bus1.ins_valid;
        g_gnt = bus1.ldr_gnt; g_busy = bus1.busy;
      end else begin
        g_pc = bus3.pc; g_ia = bus3.iram_addr; g_rd = bus3.iram_rd;
        g_mb = bus3.mbru_read_enable; g_iv = bus3.ins_valid;
        g_gnt = bus3.ldr_gnt; g_busy = bus3.busy;
      end
      p = $sformatf("lat%0d.", lat[i]);
      check({p, "pc"},        32'(g_pc),   32'(m_pc[i]));
      check({p, "iram_rd"},   32'(g_rd),   32'(m_fetch[i] && m_k[i] == 1));
      check({p, "mbru_en"},   32'(g_mb),   32'(m_fetch[i] && m_k[i] == lat[i] + 1));
      check({p, "ins_valid"}, 32'(g_iv),   32'(m_fetch[i] && m_k[i] == lat[i] + 2));
      check({p, "ldr_gnt"},   32'(g_gnt),  32'(m_ldr[i]));
      check({p, "busy"},      32'(g_busy), 32'(m_fetch[i] || m_ldr[i]));
      if (m_fetch[i] && m_k[i] <= lat[i])
        check({p, "iram_addr"}, 32'(g_ia), 32'(m_iaddr[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    fr = 0; jmp = 0; lr = 0;
    repeat (n) step();
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear at once.
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    check("rst.iram_addr1", 32'(bus1.iram_addr), 32'd0);
    check("rst.iram_addr3", 32'(bus3.iram_addr), 32'd0);
    repeat (2) step();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    check("rst0.iram_addr", 32'(bus3.iram_addr), 32'd0);
    step();
    rst_n = 1;

    // Basic fetch from address 0 after reset, RD_LAT=1 timing.
    fr = 1; step(); fr = 0;
    check("r031.iram_rd", 32'(bus1.iram_rd), 32'd1);
    check("r031.iram_addr", 32'(bus1.iram_addr), 32'd0);
    step();
    check("r031.mbru_en", 32'(bus1.mbru_read_enable), 32'd1);
    step();
    check("r031.ins_valid", 32'(bus1.ins_valid), 32'd1);
    check("r031.pc", 32'(bus1.pc), 32'd1);
    idle(6);

    // PC wrap at 255 with RD_LAT=3.
    jmp = 1; ja = 8'hFF; step(); jmp = 0;
    fr = 1; step(); fr = 0;
    check("r032.iram_addr", 32'(bus3.iram_addr), 32'hFF);
    check("r032.iram_rd", 32'(bus3.iram_rd), 32'd1);
    repeat (3) step();
    check("r032.mbru_en", 32'(bus3.mbru_read_enable), 32'd1);
    step();
    check("r032.ins_valid", 32'(bus3.ins_valid), 32'd1);
    check("r032.pc_wrap", 32'(bus3.pc), 32'd0);
    idle(3);

    // Jump together with fetch in IDLE.
    jmp = 1; ja = 8'h40; fr = 1; step(); jmp = 0; fr = 0;
    check("r033.iaddr3", 32'(bus3.iram_addr), 32'h40);
    check("r033.iaddr1", 32'(bus1.iram_addr), 32'h40);
    step(); step();
    check("r033.pc1", 32'(bus1.pc), 32'h41);
    step(); step();
    check("r033.pc3", 32'(bus3.pc), 32'h41);
    idle(3);

    // Jump arriving during WAIT is applied at LATCH.
    fr = 1; step(); fr = 0;
    step();
    jmp = 1; ja = 8'h80; step(); jmp = 0;
    step(); step();
    check("r033.pend_pc3", 32'(bus3.pc), 32'h80);
    idle(3);

    // Loader wins over a simultaneous fetch; exit resets PC.
    lr = 1; fr = 1; step(); fr = 0;
    check("r034.ldr_gnt", 32'(bus1.ldr_gnt), 32'd1);
    check("r034.no_rd", 32'(bus1.iram_rd), 32'd0);
    step(); step();
    lr = 0; step();
    check("r034.pc0", 32'(bus1.pc), 32'd0);
    check("r034.gnt_off", 32'(bus1.ldr_gnt), 32'd0);
    fr = 1; step(); fr = 0;
    check("r034.iaddr", 32'(bus1.iram_addr), 32'd0);
    check("r034.iram_rd", 32'(bus1.iram_rd), 32'd1);
    idle(6);

    // Loader request during WAIT does not preempt the fetch.
    fr = 1; step(); fr = 0;
    step();
    lr = 1;
    step(); step(); step();
    check("r035.ins_valid", 32'(bus3.ins_valid), 32'd1);
    check("r035.no_gnt", 32'(bus3.ldr_gnt), 32'd0);
    step(); step();
    check("r035.gnt", 32'(bus3.ldr_gnt), 32'd1);
    idle(4);

    // Reset during WAIT aborts the fetch cleanly.
    jmp = 1; ja = 8'h33; step(); jmp = 0;
    fr = 1; step(); fr = 0;
    step();
    do_reset();
    idle(8);
    fr = 1; step(); fr = 0;
    check("r036.iaddr3", 32'(bus3.iram_addr), 32'd0);
    check("r036.iaddr1", 32'(bus1.iram_addr), 32'd0);
    idle(6);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      fr  = ($urandom_range(0, 3) == 0);
      jmp = ($urandom_range(0, 7) == 0);
      ja  = AW'($urandom);
      if ($urandom_range(0, 19) == 0) lr = ~lr;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
